// File: rtl/pe_feeder.sv
// Streams stored reference/query symbols into B skewed lanes for a systolic PE array.
// Define FEEDER_BACKPRESSURE_EN to let down_ready stall the wavefront step counter.
module pe_feeder #(
    parameter int unsigned B = 4,
    parameter int unsigned L = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_ref,
    input  logic [2:0]       in_qry,
    input  logic             down_ready,
    output logic [7:0]       ctr,
    output logic [3*B-1:0]   R,
    output logic [3*B-1:0]   Q,
    output logic             run_valid,
    output logic             done
);

    localparam int unsigned AW     = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned CW     = $clog2(L + 1);
    localparam logic [2:0]  PAD    = 3'b100;
    localparam logic [7:0]  T_LAST = 8'(2 * L - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    load_cnt_q, load_cnt_d;
    logic [7:0]       t_q, t_d;
    logic [7:0]       ctr_q, ctr_d;
    logic [3*B-1:0]   r_q, r_d;
    logic [3*B-1:0]   q_q, q_d;
    logic             run_valid_q, run_valid_d;
    logic             done_q, done_d;

    logic [2:0]       ref_mem_q [L];
    logic [2:0]       qry_mem_q [L];

    logic             wr_en;
    logic             advance;
    logic [3*B-1:0]   r_lanes;
    logic [3*B-1:0]   q_lanes;

`ifdef FEEDER_BACKPRESSURE_EN
    assign advance = (state_q == RUN) && down_ready;
`else
    logic unused_down_ready;
    assign unused_down_ready = down_ready;
    assign advance = (state_q == RUN);
`endif

    assign in_ready = (state_q == LOAD);
    assign wr_en    = (state_q == LOAD) && in_valid;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        case (state_q)
            IDLE: begin
                state_d    = LOAD;
                load_cnt_d = '0;
                t_d        = '0;
            end
            LOAD: begin
                if (in_valid) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == CW'(L - 1)) begin
                        state_d = RUN;
                        t_d     = '0;
                    end
                end
            end
            RUN: begin
                if (advance) begin
                    if (t_q == T_LAST) begin
                        state_d = DONE;
                    end else begin
                        t_d = t_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d    = LOAD;
                load_cnt_d = '0;
                t_d        = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reference lane k lags by k steps; query lane k lags by B-1-k steps.
    always_comb begin
        r_lanes = '0;
        q_lanes = '0;
        for (int unsigned k = 0; k < B; k++) begin
            r_lanes[3*k +: 3] = PAD;
            q_lanes[3*k +: 3] = PAD;
            if ((32'(t_q) >= k) && (32'(t_q) - k < L)) begin
                r_lanes[3*k +: 3] = ref_mem_q[AW'(32'(t_q) - k)];
            end
            if ((32'(t_q) >= B - 1 - k) && (32'(t_q) - (B - 1 - k) < L)) begin
                q_lanes[3*k +: 3] = qry_mem_q[AW'(32'(t_q) - (B - 1 - k))];
            end
        end
    end

    // A stalled RUN cycle keeps the last step visible but withdraws run_valid.
    always_comb begin
        ctr_d       = '0;
        r_d         = '0;
        q_d         = '0;
        run_valid_d = 1'b0;
        done_d      = (state_q == DONE);
        if (advance) begin
            ctr_d       = t_q;
            r_d         = r_lanes;
            q_d         = q_lanes;
            run_valid_d = 1'b1;
        end else if (state_q == RUN) begin
            ctr_d = ctr_q;
            r_d   = r_q;
            q_d   = q_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            t_q         <= '0;
            ctr_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            run_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            t_q         <= t_d;
            ctr_q       <= ctr_d;
            r_q         <= r_d;
            q_q         <= q_d;
            run_valid_q <= run_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ref_mem_q[load_cnt_q[AW-1:0]] <= in_ref;
            qry_mem_q[load_cnt_q[AW-1:0]] <= in_qry;
        end
    end

    assign ctr       = ctr_q;
    assign R         = r_q;
    assign Q         = q_q;
    assign run_valid = run_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed self-checking bench for pe_feeder (B=4, L=8): load, run sweep, aborts, stalls.
module tb_pe_feeder;

    localparam int B = 4;
    localparam int L = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_ref;
    logic [2:0]    in_qry;
    logic          down_ready;
    logic [7:0]    ctr;
    logic [3*B-1:0] R;
    logic [3*B-1:0] Q;
    logic          run_valid;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [2:0] cur_ref [L];
    logic [2:0] cur_qry [L];

    pe_feeder #(.B(B), .L(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ref     (in_ref),
        .in_qry     (in_qry),
        .down_ready (down_ready),
        .ctr        (ctr),
        .R          (R),
        .Q          (Q),
        .run_valid  (run_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] enc(input byte ch);
        case (ch)
            "A": return 3'b000;
            "C": return 3'b001;
            "G": return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    task automatic set_data(input string rs, input string qs);
        for (int i = 0; i < L; i++) begin
            cur_ref[i] = enc(rs[i]);
            cur_qry[i] = enc(qs[i]);
        end
    endtask

    function automatic logic [3*B-1:0] exp_r(input int t);
        logic [3*B-1:0] v;
        int idx;
        v = '0;
        for (int k = 0; k < B; k++) begin
            idx = t - k;
            v[3*k +: 3] = (idx >= 0 && idx < L) ? cur_ref[idx[2:0]] : 3'b100;
        end
        return v;
    endfunction

    function automatic logic [3*B-1:0] exp_q(input int t);
        logic [3*B-1:0] v;
        int idx;
        v = '0;
        for (int k = 0; k < B; k++) begin
            idx = t - (B - 1 - k);
            v[3*k +: 3] = (idx >= 0 && idx < L) ? cur_qry[idx[2:0]] : 3'b100;
        end
        return v;
    endfunction

    // Presents n pairs from cur_ref/cur_qry; with toggle, a junk low-valid cycle follows each pair.
    task automatic load_pairs(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_ref   = cur_ref[i];
            in_qry   = cur_qry[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready pair %0d got %b want 1", i, in_ready);
            end
            tick;
            if (toggle && i < n - 1) begin
                in_valid = 1'b0;
                in_ref   = 3'b101;
                in_qry   = 3'b110;
                tick;
            end
        end
        in_valid = 1'b0;
        in_ref   = 3'b000;
        in_qry   = 3'b000;
        checks++;
        if (in_ready !== ((n == L) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL load_end_ready after %0d pairs got %b want %b", n, in_ready, (n == L) ? 1'b0 : 1'b1);
        end
    endtask

    // Follows one run from the cycle RUN is entered through the done pulse.
    task automatic run_check(input string name, input int stall_at, input bit noise, input bit fixed);
        int n_valid = 0;
        int done_cnt = 0;
        int done_at = -1;
        int stalls = 0;
        int stall_left = 0;
        int exp_stalls = 0;
        logic [7:0]     last_ctr = '0;
        logic [3*B-1:0] last_r = '0;
        logic [3*B-1:0] last_q = '0;
`ifdef FEEDER_BACKPRESSURE_EN
        if (stall_at >= 0) exp_stalls = 3;
`endif
        checks++;
        if (run_valid !== 1'b0 || ctr !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_entry rv=%b ctr=%0d rdy=%b want 0 0 0", name, run_valid, ctr, in_ready);
        end
        if (noise) begin
            in_valid = 1'b1;
            in_ref   = 3'b110;
            in_qry   = 3'b101;
        end
        for (int c = 1; c <= 40; c++) begin
            if (done_at >= 0 && c > done_at + 2) break;
            tick;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    checks++;
                    if (run_valid !== 1'b0 || ctr !== 8'd0 || R !== '0 || Q !== '0 || in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_done_idle rv=%b ctr=%0d R=%h Q=%h rdy=%b want 0 0 0 0 1",
                                 name, run_valid, ctr, R, Q, in_ready);
                    end
                end
            end
            if (run_valid) begin
                checks++;
                if (ctr !== 8'(n_valid)) begin
                    errors++;
                    $display("FAIL %s_ctr got %0d want %0d", name, ctr, n_valid);
                end
                checks++;
                if (R !== exp_r(n_valid)) begin
                    errors++;
                    $display("FAIL %s_R t=%0d got %b want %b", name, n_valid, R, exp_r(n_valid));
                end
                checks++;
                if (Q !== exp_q(n_valid)) begin
                    errors++;
                    $display("FAIL %s_Q t=%0d got %b want %b", name, n_valid, Q, exp_q(n_valid));
                end
                if (fixed && n_valid == 0) begin
                    checks++;
                    if (R !== 12'b100_100_100_000 || Q !== 12'b011_100_100_100) begin
                        errors++;
                        $display("FAIL %s_fixed0 R=%b Q=%b want 100100100000 011100100100", name, R, Q);
                    end
                end
                if (fixed && n_valid == 9) begin
                    checks++;
                    if (R !== 12'b010_011_100_100 || Q !== 12'b100_100_000_000) begin
                        errors++;
                        $display("FAIL %s_fixed9 R=%b Q=%b want 010011100100 100100000000", name, R, Q);
                    end
                end
                n_valid++;
                last_ctr = ctr;
                last_r   = R;
                last_q   = Q;
            end else if (n_valid > 0 && n_valid < 2 * L) begin
                stalls++;
                checks++;
                if (ctr !== last_ctr || R !== last_r || Q !== last_q) begin
                    errors++;
                    $display("FAIL %s_hold ctr=%0d R=%h Q=%h want %0d %h %h", name, ctr, R, Q, last_ctr, last_r, last_q);
                end
            end
            if (done_at >= 0) in_valid = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) down_ready = 1'b1;
            end else if (run_valid && int'(ctr) == stall_at) begin
                down_ready = 1'b0;
                stall_left = 3;
            end
        end
        in_valid   = 1'b0;
        down_ready = 1'b1;
        checks++;
        if (n_valid != 2 * L) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", name, n_valid, 2 * L);
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s_stalls got %0d want %0d", name, stalls, exp_stalls);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt);
        end
        checks++;
        if (done_at != 17 + exp_stalls) begin
            errors++;
            $display("FAIL %s_done_cycle got %0d want %0d", name, done_at, 17 + exp_stalls);
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_ref     = 3'b001;
        in_qry     = 3'b010;
        down_ready = 1'b1;
        tick;
        tick;
        checks++;
        if (in_ready !== 1'b0 || run_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl rdy=%b rv=%b done=%b want 0 0 0", in_ready, run_valid, done);
        end
        checks++;
        if (ctr !== 8'd0 || R !== '0 || Q !== '0) begin
            errors++;
            $display("FAIL reset_data ctr=%0d R=%h Q=%h want 0 0 0", ctr, R, Q);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_load rdy=%b want 1", in_ready);
        end
    endtask

    task automatic test_baseline;
        set_data("ACGTACGT", "TTTTAAAA");
        load_pairs(L, 1'b0);
        run_check("base", -1, 1'b0, 1'b1);
    endtask

    task automatic test_toggle_load;
        set_data("GATTACAG", "CCGTAGCA");
        load_pairs(L, 1'b1);
        run_check("toggle", -1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_abort;
        bit found = 1'b0;
        set_data("TTGGCCAA", "ACACGTGT");
        load_pairs(L, 1'b0);
        for (int c = 0; c < 30; c++) begin
            tick;
            if (run_valid && ctr == 8'd5) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_ctr5 got none want ctr=5 within 30 cycles");
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (run_valid !== 1'b0 || ctr !== 8'd0 || R !== '0 || Q !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle rv=%b ctr=%0d R=%h Q=%h rdy=%b want 0 0 0 0 0", run_valid, ctr, R, Q, in_ready);
        end
        tick;
        set_data("CATGCATG", "GGGAAATT");
        load_pairs(4, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        load_pairs(L, 1'b0);
        run_check("abort", -1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        set_data("ACGTACGT", "TTTTAAAA");
        load_pairs(L, 1'b0);
        run_check("bp", 4, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset;
        test_baseline;
        test_toggle_load;
        test_reset_abort;
        test_backpressure;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
